// File: rtl/lc3_mem_pkg.sv
// Shared types and defaults for the MAR/MDR memory-access stage.
// Consumed by mem_access_unit, mem_access_fsm and mem_access_unit_if.
package lc3_mem_pkg;

    localparam int unsigned DEF_WORD_W         = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    // Timeout counter width: enough to hold TIMEOUT_CYCLES, never below 4 bits.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// External memory port: request/ack handshake with address, write data and read data.
// master = access unit, slave = memory model or controller.
interface mem_access_unit_if
    import lc3_mem_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W
) ();

    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/mem_access_unit_fsm.sv
// Transaction sequencer for the memory-access stage: IDLE -> REQ -> DONE handshake.
// MEM_TIMEOUT_EN adds a REQ watchdog that aborts to DONE and raises a sticky err.
module mem_access_fsm
    import lc3_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       mio_en,
    input  logic       r_w,
    input  logic       mem_ack,
    output mem_state_e state,
    output logic       mem_req,
    output logic       mem_we,
    output logic       r,
    output logic       err,
    output logic       cap_rdata
);

    mem_state_e state_q, state_d;
    logic       we_q, we_d;
    logic       timeout;

    always_ff @(posedge clk) begin
        if (reset_) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        unique case (state_q)
            IDLE: begin
                if (mio_en) begin
                    state_d = REQ;
                    we_d    = r_w;
                end
            end
            REQ: begin
                // An ack on the same cycle as the watchdog firing is a normal completion.
                if (mem_ack || timeout) state_d = DONE;
            end
            DONE: begin
                if (!mio_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign timeout = (state_q == REQ) && !mem_ack &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset_) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == IDLE && mio_en) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (state_q == REQ && !mem_ack) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (timeout) err_d = 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    assign state     = state_q;
    assign mem_req   = (state_q == REQ);
    assign mem_we    = (state_q == REQ) && we_q;
    assign r         = (state_q == DONE);
    assign cap_rdata = (state_q == REQ) && mem_ack && !we_q;

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR memory-interface stage: captures the bus into MAR/MDR and runs req/ack accesses.
// Optional REQ watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
    import lc3_mem_pkg::*;
#(
    parameter int unsigned WORD_W         = DEF_WORD_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic [WORD_W-1:0] bus,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              mio_en,
    input  logic              r_w,
    output logic [WORD_W-1:0] mar,
    output logic [WORD_W-1:0] mdr,
    output logic              r,
    output logic              err,
    mem_access_unit_if.master mem
);

    mem_state_e        state;
    logic              cap_rdata;
    logic              idle;
    logic [WORD_W-1:0] mar_q, mdr_q;

    mem_access_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fsm (
        .clk       (clk),
        .reset_    (reset_),
        .mio_en    (mio_en),
        .r_w       (r_w),
        .mem_ack   (mem.mem_ack),
        .state     (state),
        .mem_req   (mem.mem_req),
        .mem_we    (mem.mem_we),
        .r         (r),
        .err       (err),
        .cap_rdata (cap_rdata)
    );

    assign idle = (state == IDLE);

    // MAR/MDR are frozen outside IDLE so address and write data stay stable for the access.
    // An MDR bus load yields to a starting access: reads overwrite it, writes use the old value.
    always_ff @(posedge clk) begin
        if (reset_) begin
            mar_q <= '0;
            mdr_q <= '0;
        end else begin
            if (idle && ld_mar) mar_q <= bus;
            if (cap_rdata)
                mdr_q <= mem.mem_rdata;
            else if (idle && ld_mdr && !mio_en)
                mdr_q <= bus;
        end
    end

    assign mar           = mar_q;
    assign mdr           = mdr_q;
    assign mem.mem_addr  = mar_q;
    assign mem.mem_wdata = mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_mem_access_unit;
    import lc3_mem_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned TO = DEF_TIMEOUT_CYCLES;

    logic         clk = 1'b0;
    logic         reset_, ld_mar, ld_mdr, mio_en, r_w;
    logic [W-1:0] bus, mar, mdr;
    logic         r, err;

    always #5 clk = ~clk;

    mem_access_unit_if #(.WORD_W(W)) mif ();

    mem_access_unit #(
        .WORD_W        (W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus),
        .ld_mar (ld_mar),
        .ld_mdr (ld_mdr),
        .mio_en (mio_en),
        .r_w    (r_w),
        .mar    (mar),
        .mdr    (mdr),
        .r      (r),
        .err    (err),
        .mem    (mif)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Transaction-level model: an access is either in flight, completed-and-held, or absent.
    logic [W-1:0] m_mar = '0, m_mdr = '0;
    bit           m_busy = 0, m_ready = 0, m_we = 0, m_err = 0;
    int           m_wait = 0;

    always @(posedge clk) begin
        if (reset_) begin
            m_mar <= '0; m_mdr <= '0;
            m_busy <= 0; m_ready <= 0; m_we <= 0; m_err <= 0; m_wait <= 0;
        end else if (m_busy) begin
            if (mif.mem_ack) begin
                if (!m_we) m_mdr <= mif.mem_rdata;
                m_busy <= 0; m_ready <= 1;
            end
`ifdef MEM_TIMEOUT_EN
            else if (m_wait + 1 == int'(TO)) begin
                m_busy <= 0; m_ready <= 1; m_err <= 1;
            end
`endif
            else m_wait <= m_wait + 1;
        end else if (m_ready) begin
            if (!mio_en) m_ready <= 0;
        end else begin
            if (ld_mar) m_mar <= bus;
            if (ld_mdr && !mio_en) m_mdr <= bus;
            if (mio_en) begin
                m_busy <= 1; m_we <= r_w; m_wait <= 0; m_err <= 0;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp("mar",       32'(mar),           32'(m_mar));
            cmp("mdr",       32'(mdr),           32'(m_mdr));
            cmp("r",         32'(r),             32'(m_ready));
            cmp("mem_req",   32'(mif.mem_req),   32'(m_busy));
            cmp("mem_we",    32'(mif.mem_we),    32'(m_busy & m_we));
            cmp("mem_addr",  32'(mif.mem_addr),  32'(m_mar));
            cmp("mem_wdata", 32'(mif.mem_wdata), 32'(m_mdr));
            cmp("err",       32'(err),           32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0;
        mif.mem_ack = 0; mif.mem_rdata = '0; bus = '0;
    endtask

    initial begin
        reset_ = 1; idle_inputs();
        step(); step();
        cmp("reset_mar", 32'(mar), 32'h0);
        cmp("reset_mdr", 32'(mdr), 32'h0);
        cmp("reset_r",   32'(r),   32'h0);
        cmp("reset_req", 32'(mif.mem_req), 32'h0);
        cmp("reset_err", 32'(err), 32'h0);
        reset_ = 0;
        cmp_en = 1;
        step();

        // Read, zero wait
        bus = 16'h3000; ld_mar = 1; step();
        ld_mar = 0; mio_en = 1; r_w = 0; step();
        cmp("rd0_req",  32'(mif.mem_req),  32'h1);
        cmp("rd0_addr", 32'(mif.mem_addr), 32'h3000);
        cmp("rd0_r_early", 32'(r), 32'h0);
        mif.mem_ack = 1; mif.mem_rdata = 16'h1234; step();
        cmp("rd0_r",   32'(r),   32'h1);
        cmp("rd0_mdr", 32'(mdr), 32'h1234);
        cmp("rd0_req_drop", 32'(mif.mem_req), 32'h0);
        mif.mem_ack = 0; step();
        cmp("rd0_r_hold", 32'(r), 32'h1);
        mio_en = 0; step();
        cmp("rd0_r_clear", 32'(r), 32'h0);

        // Write, 3-cycle wait, with freeze attempts during REQ
        bus = 16'h4000; ld_mar = 1; step();
        ld_mar = 0; bus = 16'hBEEF; ld_mdr = 1; step();
        ld_mdr = 0; mio_en = 1; r_w = 1; step();
        for (int i = 0; i < 3; i++) begin
            cmp("wr_req",   32'(mif.mem_req),   32'h1);
            cmp("wr_we",    32'(mif.mem_we),    32'h1);
            cmp("wr_wdata", 32'(mif.mem_wdata), 32'hBEEF);
            cmp("wr_addr",  32'(mif.mem_addr),  32'h4000);
            if (i == 0) begin bus = 16'h5555; ld_mar = 1; end
            if (i == 1) begin bus = 16'hAAAA; ld_mar = 0; ld_mdr = 1; end
            if (i == 2) begin ld_mdr = 0; mif.mem_ack = 1; mif.mem_rdata = 16'h9999; end
            step();
        end
        cmp("wr_r",   32'(r),   32'h1);
        cmp("wr_we_drop", 32'(mif.mem_we), 32'h0);
        cmp("wr_mdr", 32'(mdr), 32'hBEEF);
        mif.mem_ack = 0; mio_en = 0; step();
        cmp("frz_mar", 32'(mar), 32'h4000);
        cmp("frz_mdr", 32'(mdr), 32'hBEEF);

        // Same-edge MAR load and access start
        bus = 16'h0010; ld_mar = 1; mio_en = 1; r_w = 0; step();
        ld_mar = 0;
        cmp("same_addr", 32'(mif.mem_addr), 32'h0010);
        cmp("same_req",  32'(mif.mem_req),  32'h1);
        mif.mem_ack = 1; mif.mem_rdata = 16'h0777; step();
        mif.mem_ack = 0; mio_en = 0; step();

        // Reset in the middle of a pending read, then a late ack
        bus = 16'h3000; ld_mar = 1; step();
        ld_mar = 0; mio_en = 1; r_w = 0; step();
        cmp("rst_pre_req", 32'(mif.mem_req), 32'h1);
        reset_ = 1; step();
        cmp("rst_req", 32'(mif.mem_req), 32'h0);
        cmp("rst_r",   32'(r),   32'h0);
        cmp("rst_mar", 32'(mar), 32'h0);
        cmp("rst_mdr", 32'(mdr), 32'h0);
        reset_ = 0; mio_en = 0; step();
        mif.mem_ack = 1; mif.mem_rdata = 16'hFFFF; step();
        mif.mem_ack = 0;
        cmp("late_mdr", 32'(mdr), 32'h0);
        cmp("late_req", 32'(mif.mem_req), 32'h0);
        cmp("late_r",   32'(r), 32'h0);

`ifdef MEM_TIMEOUT_EN
        bus = 16'h1357; ld_mdr = 1; step();
        ld_mdr = 0; mio_en = 1; r_w = 0; step();
        for (int i = 0; i < int'(TO); i++) begin
            cmp("to_req", 32'(mif.mem_req), 32'h1);
            cmp("to_r",   32'(r), 32'h0);
            step();
        end
        cmp("to_done_r",   32'(r),   32'h1);
        cmp("to_done_err", 32'(err), 32'h1);
        cmp("to_done_mdr", 32'(mdr), 32'h1357);
        mio_en = 0; step();
        cmp("to_err_sticky", 32'(err), 32'h1);
        mio_en = 1; step();
        cmp("to_err_clear", 32'(err), 32'h0);
        mif.mem_ack = 1; mif.mem_rdata = 16'h2468; step();
        mif.mem_ack = 0; mio_en = 0; step();
`endif

        // Randomized traffic; control holds mio_en through REQ and releases it after r
        for (int i = 0; i < 3000; i++) begin
            reset_ = ($urandom_range(0, 99) == 0);
            ld_mar = ($urandom_range(0, 3) == 0);
            ld_mdr = ($urandom_range(0, 3) == 0);
            bus    = W'($urandom);
            r_w    = $urandom_range(0, 1) == 1;
            if (mif.mem_req)
                mio_en = 1;
            else if (r)
                mio_en = ($urandom_range(0, 2) == 0);
            else
                mio_en = ($urandom_range(0, 2) == 0);
            mif.mem_ack   = ($urandom_range(0, 4) == 0);
            mif.mem_rdata = W'($urandom);
            step();
        end

        reset_ = 0; idle_inputs();
        step();
        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MAR/MDR memory-interface stage directly downstream of the bus driver.
- Captures the registered 16-bit bus into MAR or MDR and runs read/write transactions to an external memory port with a req/ack handshake.
- Returns the ready flag r to the control FSM.
- The mdr output feeds the bus driver's mdr input (GateMDR path).

Parameters:
- WORD_W, 16, width of bus, MAR, MDR and memory data/address.
- TIMEOUT_CYCLES, 15, max cycles in REQ before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_  in  1  synchronous, active-high reset
- bus  in  WORD_W  registered system bus
- ld_mar  in  1  load MAR from bus
- ld_mdr  in  1  load MDR from bus when mio_en=0
- mio_en  in  1  memory access enable, held by control until r seen
- r_w  in  1  0=read, 1=write
- mar  out  WORD_W  current MAR
- mdr  out  WORD_W  current MDR, to bus driver
- r  out  1  access complete/ready
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write enable, valid with mem_req
- mem_addr  out  WORD_W  equals mar
- mem_wdata  out  WORD_W  equals mdr
- mem_rdata  in  WORD_W  read data, valid with mem_ack
- mem_ack  in  1  memory completion
- err  out  1  timeout flag

Behaviour:
- Reset (reset_=1 at edge): state=IDLE; mar=0, mdr=0, r=0, mem_req=0, mem_we=0, err=0. This takes priority over every other input, including mid-transaction; mem_req drops on that edge.
- States:
  - IDLE: mem_req=0, r=0.
  - REQ: mem_req=1; mem_we latched from r_w at entry. Address and wdata are stable because MAR and MDR are frozen.
  - DONE: r=1, mem_req=0.
- Transitions:
  - IDLE→REQ when mio_en=1.
  - REQ→DONE when mem_ack=1. An ack in the first REQ cycle is accepted.
  - DONE→IDLE when mio_en=0. DONE holds r=1 while mio_en stays 1, so a held mio_en never retriggers.
- Minimum latency: mio_en sampled in cycle N; mem_req in N+1; ack in N+1 gives r=1 in N+2.
- Read: on the ack edge, mdr<=mem_rdata. Write: mdr unchanged; memory takes mem_wdata at ack.
- ld_mar in IDLE: mar<=bus.
- ld_mdr in IDLE with mio_en=0: mdr<=bus.
- ld_mar/ld_mdr in REQ or DONE: ignored.
- Simultaneous ld_mar and mio_en in IDLE: MAR loads the bus value, and the access uses that new MAR.
- ld_mdr with mio_en=1 in IDLE: the bus load is ignored. A read overwrites MDR; a write uses the old MDR.
- mem_ack while in IDLE or DONE is ignored.
- mem_rdata is sampled only on the ack edge in REQ with mem_we=0.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A 4-bit+ counter clears on REQ entry and increments each REQ cycle without ack.
  - On reaching TIMEOUT_CYCLES: REQ→DONE, mem_req drops, mdr unchanged, err=1.
  - err stays sticky until the next IDLE→REQ transition or reset.
  - An ack on the same cycle as timeout wins: normal completion, err=0.
- Undefined: no counter; err tied 0; REQ waits indefinitely.

Decomposition:
- Shared package lc3_mem_pkg holds:
  - state enum {IDLE, REQ, DONE}
  - WORD_W default
  - TIMEOUT_CYCLES default
- One sub-module, mem_access_fsm:
  - Inputs: mio_en, r_w, mem_ack, and timeout logic.
  - Outputs: state, mem_req, mem_we, r, err, and capture/freeze strobes.
- MAR/MDR registers and muxing stay in the top module.

Test Plan:
- Reset mid-REQ:
  - Stimulus: mar=0x3000, read pending, assert reset_.
  - Required: next cycle mem_req=0, r=0, mar=0, mdr=0. A late ack 2 cycles later leaves mdr=0 and state IDLE.
- Read, zero wait:
  - Stimulus: bus=0x3000 with ld_mar; next cycle mio_en=1, r_w=0; memory acks in the first REQ cycle with rdata=0x1234.
  - Required: mem_addr=0x3000; mdr=0x1234 and r=1 exactly 2 cycles after mio_en sampled; r stays high until mio_en drops.
- Write, 3-cycle wait:
  - Stimulus: mar=0x4000, ld_mdr bus=0xBEEF, mio_en=1, r_w=1; ack on the 3rd REQ cycle.
  - Required: mem_req/mem_we high for 3 cycles; mem_wdata=0xBEEF; mdr stays 0xBEEF.
- Freeze:
  - Stimulus: during REQ, ld_mar with bus=0x5555 and ld_mdr with bus=0xAAAA.
  - Required: mem_addr and mem_wdata unchanged; after return to IDLE, mar and mdr still hold their prior values.
- Same-edge load:
  - Stimulus: in IDLE, ld_mar with bus=0x0010 and mio_en=1 together.
  - Required: mem_addr=0x0010 on the first REQ cycle.
- Timeout (MEM_TIMEOUT_EN defined):
  - Stimulus: no ack.
  - Required: after 15 REQ cycles, r=1, err=1, mdr unchanged. The next access clears err on entry to REQ.
